// File: rtl/load_store_unit.sv
// Memory-access stage: effective-address generation, a req/ack data-memory
// transaction with timeout, load-data formatting and register writeback requests.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        cond_pass,
  input  logic        load_store,
  input  logic        byte_or_word,
  input  logic        pre_post,
  input  logic        up_down,
  input  logic        write_back,
  input  logic [31:0] base_data,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rn_we,
  output logic [3:0]  rn_addr,
  output logic [31:0] rn_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        is_load, is_load_nxt;
  logic        is_byte, is_byte_nxt;
  logic        do_wb, do_wb_nxt;
  logic [1:0]  lane, lane_nxt;
  logic [31:0] sum_q, sum_nxt;

  logic        mem_req_nxt, mem_we_nxt, busy_nxt, done_nxt, fault_nxt;
  logic        rd_we_nxt, rn_we_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt, rd_data_nxt, rn_data_nxt;
  logic [3:0]  mem_be_nxt, rd_addr_nxt, rn_addr_nxt;

  logic [31:0] sum_in, eff_in;

  function automatic logic [3:0] store_be(input logic is_b, input logic [1:0] ln);
    store_be = is_b ? (4'b0001 << ln) : 4'hF;
  endfunction

  function automatic logic [31:0] store_word(input logic is_b, input logic [31:0] d);
    store_word = is_b ? {4{d[7:0]}} : d;
  endfunction

  // Word loads rotate the aligned word so the addressed byte lands in bits 7:0.
  function automatic logic [31:0] load_format(input logic [31:0] d, input logic [1:0] ln,
                                              input logic is_b);
    logic [63:0] dbl;
    dbl = {d, d} >> {ln, 3'b000};
    load_format = is_b ? {24'd0, dbl[7:0]} : dbl[31:0];
  endfunction

  always_comb begin
    sum_in = up_down ? (base_data + offset) : (base_data - offset);
    eff_in = pre_post ? sum_in : base_data;
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      is_load   <= 1'b0;
      is_byte   <= 1'b0;
      do_wb     <= 1'b0;
      lane      <= 2'd0;
      sum_q     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rd_we     <= 1'b0;
      rd_addr   <= 4'd0;
      rd_data   <= 32'd0;
      rn_we     <= 1'b0;
      rn_addr   <= 4'd0;
      rn_data   <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_load   <= is_load_nxt;
      is_byte   <= is_byte_nxt;
      do_wb     <= do_wb_nxt;
      lane      <= lane_nxt;
      sum_q     <= sum_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_be    <= mem_be_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      fault     <= fault_nxt;
      rd_we     <= rd_we_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_data   <= rd_data_nxt;
      rn_we     <= rn_we_nxt;
      rn_addr   <= rn_addr_nxt;
      rn_data   <= rn_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cond_pass ? ACCESS : WB;
      ACCESS:  if (mem_ack || cnt == LAST_CNT) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt       = cnt;
    is_load_nxt   = is_load;
    is_byte_nxt   = is_byte;
    do_wb_nxt     = do_wb;
    lane_nxt      = lane;
    sum_nxt       = sum_q;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;
    busy_nxt      = busy;
    done_nxt      = done;
    fault_nxt     = fault;
    rd_we_nxt     = rd_we;
    rd_addr_nxt   = rd_addr;
    rd_data_nxt   = rd_data;
    rn_we_nxt     = rn_we;
    rn_addr_nxt   = rn_addr;
    rn_data_nxt   = rn_data;
    case (state)
      IDLE: begin
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        fault_nxt   = 1'b0;
        rd_we_nxt   = 1'b0;
        rn_we_nxt   = 1'b0;
        mem_req_nxt = 1'b0;
        if (start) begin
          is_load_nxt = load_store;
          is_byte_nxt = byte_or_word;
          do_wb_nxt   = write_back | ~pre_post;
          lane_nxt    = eff_in[1:0];
          sum_nxt     = sum_in;
          rd_addr_nxt = rd;
          rn_addr_nxt = rn;
          cnt_nxt     = 8'd0;
          busy_nxt    = 1'b1;
          if (cond_pass) begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = ~load_store;
            mem_addr_nxt  = {eff_in[31:2], 2'b00};
            mem_be_nxt    = load_store ? 4'hF : store_be(byte_or_word, eff_in[1:0]);
            mem_wdata_nxt = store_word(byte_or_word, store_data);
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          done_nxt    = 1'b1;
          rd_we_nxt   = is_load;
          // A load into the base register takes priority over base writeback.
          rn_we_nxt   = do_wb & ~(is_load & (rd_addr == rn_addr));
          rn_data_nxt = sum_q;
          if (is_load) rd_data_nxt = load_format(mem_rdata, lane, is_byte);
        end else if (cnt == LAST_CNT) begin
          mem_req_nxt = 1'b0;
          done_nxt    = 1'b1;
          fault_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      WB: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        fault_nxt = 1'b0;
        rd_we_nxt = 1'b0;
        rn_we_nxt = 1'b0;
      end
      default: begin
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a behavioural model
// of address generation, byte-lane handling and writeback rules.
module tb_load_store_unit;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        nreset, start, cond_pass, load_store, byte_or_word, pre_post, up_down, write_back;
  logic [31:0] base_data, offset, store_data, mem_rdata;
  logic [3:0]  rd, rn;
  logic        mem_req, mem_we, mem_ack, busy, done, fault, rd_we, rn_we;
  logic [31:0] mem_addr, mem_wdata, rd_data, rn_data;
  logic [3:0]  mem_be, rd_addr, rn_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr, obs_wdata, obs_rd, obs_rn;
  logic [3:0]  obs_be;
  logic        obs_we, obs_rd_we, obs_rn_we;
  int          obs_cyc;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nreset(nreset), .start(start), .cond_pass(cond_pass),
    .load_store(load_store), .byte_or_word(byte_or_word), .pre_post(pre_post),
    .up_down(up_down), .write_back(write_back), .base_data(base_data),
    .offset(offset), .store_data(store_data), .rd(rd), .rn(rn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
    .done(done), .fault(fault), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rn_we(rn_we), .rn_addr(rn_addr), .rn_data(rn_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic scramble();
    load_store   = 1'($urandom);
    byte_or_word = 1'($urandom);
    pre_post     = 1'($urandom);
    up_down      = 1'($urandom);
    write_back   = 1'($urandom);
    cond_pass    = 1'($urandom);
    base_data    = $urandom;
    offset       = $urandom;
    store_data   = $urandom;
    rd           = 4'($urandom);
    rn           = 4'($urandom);
  endtask

  // One instruction: ack_after = req cycle on which ack is given (0 = never).
  task automatic txn(input bit cp, input bit ls, input bit bw, input bit pp, input bit ud,
                     input bit wb, input logic [31:0] base, input logic [31:0] off,
                     input logic [31:0] sd, input logic [3:0] rdi, input logic [3:0] rni,
                     input int ack_after, input logic [31:0] rdata, input bit spam);
    logic [31:0] sum, eff, e_addr, e_wdata, e_rd, e_rn;
    logic [3:0]  e_be;
    logic [1:0]  ln;
    int          sh, cyc, n, e_n, e_cyc;
    bit          e_fault, e_rd_we, e_rn_we;
    sum    = ud ? base + off : base - off;
    eff    = pp ? sum : base;
    e_addr = eff & 32'hFFFF_FFFC;
    ln     = eff[1:0];
    sh     = 8 * int'(ln);
    e_be   = (!ls && bw) ? (4'b0001 << ln) : 4'hF;
    e_wdata = bw ? {sd[7:0], sd[7:0], sd[7:0], sd[7:0]} : sd;
    if (bw) e_rd = (rdata >> sh) & 32'hFF;
    else    e_rd = (sh == 0) ? rdata : ((rdata >> sh) | (rdata << (32 - sh)));
    e_rn    = sum;
    e_fault = cp && ack_after == 0;
    e_rd_we = cp && !e_fault && ls;
    e_rn_we = cp && !e_fault && (wb || !pp) && !(ls && rdi == rni);
    e_n     = !cp ? 0 : (ack_after == 0 ? T : ack_after);
    e_cyc   = e_n + 1;

    cond_pass = cp; load_store = ls; byte_or_word = bw; pre_post = pp; up_down = ud;
    write_back = wb; base_data = base; offset = off; store_data = sd; rd = rdi; rn = rni;
    start = 1'b1;
    tick();
    start = spam;
    scramble();
    cyc = 1;
    n = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (mem_req === 1'b1) begin
        n++;
        if (n == 1) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
        end
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(!ls));
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (!ls) chk("mem_wdata", mem_wdata, e_wdata);
        chk("busy_access", 32'(busy), 32'd1);
        if (n == ack_after) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      cyc++;
    end
    start = 1'b0;
    obs_cyc = cyc; obs_rd = rd_data; obs_rn = rn_data; obs_rd_we = rd_we; obs_rn_we = rn_we;
    chk("done_seen", 32'(done), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(e_cyc));
    chk("req_cycles", 32'(n), 32'(e_n));
    chk("req_dropped", 32'(mem_req), 32'd0);
    chk("fault", 32'(fault), 32'(e_fault));
    chk("rd_we", 32'(rd_we), 32'(e_rd_we));
    chk("rn_we", 32'(rn_we), 32'(e_rn_we));
    chk("rd_addr", 32'(rd_addr), 32'(rdi));
    chk("rn_addr", 32'(rn_addr), 32'(rni));
    if (e_rd_we) chk("rd_data", rd_data, e_rd);
    if (e_rn_we) chk("rn_data", rn_data, e_rn);
    if (spam) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rd_we_idle", 32'(rd_we), 32'd0);
    chk("rn_we_idle", 32'(rn_we), 32'd0);
    if (spam) begin
      for (int i = 0; i < 3; i++) begin
        chk("spam_no_req", 32'(mem_req), 32'd0);
        chk("spam_no_done", 32'(done), 32'd0);
        tick();
      end
    end
  endtask

  task automatic test_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_rn_we", 32'(rn_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rn_data", rn_data, 32'd0);
  endtask

  task automatic test_directed();
    txn(1, 1, 0, 1, 1, 0, 32'h100, 32'h8, 32'h0, 4'd1, 4'd2, 3, 32'hDEADBEEF, 0);
    chk("ldr_addr", obs_addr, 32'h108);
    chk("ldr_done_cyc", 32'(obs_cyc), 32'd4);
    chk("ldr_data", obs_rd, 32'hDEADBEEF);
    chk("ldr_rn_we", 32'(obs_rn_we), 32'd0);
    txn(1, 0, 1, 0, 0, 1, 32'h203, 32'h4, 32'h12345678, 4'd3, 4'd4, 1, 32'h0, 0);
    chk("strb_addr", obs_addr, 32'h200);
    chk("strb_be", 32'(obs_be), 32'h8);
    chk("strb_wdata", obs_wdata, 32'h78787878);
    chk("strb_we", 32'(obs_we), 32'd1);
    chk("strb_rn_we", 32'(obs_rn_we), 32'd1);
    chk("strb_rn_data", obs_rn, 32'h1FF);
    txn(1, 1, 0, 1, 1, 0, 32'h100, 32'h2, 32'h0, 4'd5, 4'd6, 1, 32'h11223344, 0);
    chk("ldr_unaligned", obs_rd, 32'h33441122);
    chk("ldr_zero_wait_cyc", 32'(obs_cyc), 32'd2);
    txn(1, 1, 1, 1, 1, 0, 32'h101, 32'h0, 32'h0, 4'd5, 4'd6, 2, 32'h11223344, 0);
    chk("ldrb_lane1", obs_rd, 32'h00000033);
    txn(1, 0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h8, 32'hA5A5A5A5, 4'd7, 4'd8, 1, 32'h0, 0);
    chk("addr_wrap", obs_addr, 32'h4);
    // Load into the base register with writeback: only Rd is written.
    txn(1, 1, 0, 1, 1, 1, 32'h40, 32'h4, 32'h0, 4'd9, 4'd9, 2, 32'hCAFEF00D, 0);
    chk("rd_eq_rn_rd_we", 32'(obs_rd_we), 32'd1);
    chk("rd_eq_rn_rn_we", 32'(obs_rn_we), 32'd0);
  endtask

  task automatic test_cond_fail_and_busy_start();
    txn(0, 1, 0, 1, 1, 1, 32'h500, 32'h4, 32'h0, 4'd1, 4'd2, 1, 32'h0, 1);
    chk("cond_fail_cyc", 32'(obs_cyc), 32'd1);
    txn(1, 0, 0, 1, 0, 1, 32'h800, 32'h10, 32'h55AA55AA, 4'd2, 4'd3, 4, 32'h0, 1);
  endtask

  task automatic test_timeout();
    txn(1, 1, 0, 1, 1, 1, 32'h300, 32'h4, 32'h0, 4'd1, 4'd2, 0, 32'h0, 0);
    chk("timeout_cyc", 32'(obs_cyc), 32'(T + 1));
    // Ack arriving on the very last allowed cycle beats the timeout.
    txn(1, 1, 0, 1, 1, 1, 32'h300, 32'h4, 32'h0, 4'd1, 4'd2, T, 32'h87654321, 0);
    txn(1, 0, 0, 0, 1, 0, 32'h30C, 32'h4, 32'h0BADF00D, 4'd1, 4'd2, 1, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    cond_pass = 1; load_store = 1; byte_or_word = 0; pre_post = 1; up_down = 1;
    write_back = 1; base_data = 32'h600; offset = 32'h4; rd = 4'd1; rn = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_req_before", 32'(mem_req), 32'd1);
    nreset = 1'b1;
    #1;
    chk("mid_req_dropped", 32'(mem_req), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    tick();
    nreset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12121212;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_done", 32'(done), 32'd0);
      chk("late_ack_rd_we", 32'(rd_we), 32'd0);
      chk("late_ack_req", 32'(mem_req), 32'd0);
      tick();
    end
  endtask

  task automatic test_random();
    bit cp, ls, bw, pp, ud, wb;
    logic [3:0] rdi, rni;
    int ack;
    for (int i = 0; i < 40; i++) begin
      cp  = ($urandom_range(0, 9) != 0);
      ls  = 1'($urandom); bw = 1'($urandom); pp = 1'($urandom);
      ud  = 1'($urandom); wb = 1'($urandom);
      rdi = 4'($urandom);
      rni = ($urandom_range(0, 3) == 0) ? rdi : 4'($urandom);
      ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      txn(cp, ls, bw, pp, ud, wb, $urandom, $urandom, $urandom, rdi, rni, ack, $urandom,
          1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    nreset = 1'b1; start = 1'b0; cond_pass = 1'b0; load_store = 1'b0; byte_or_word = 1'b0;
    pre_post = 1'b0; up_down = 1'b0; write_back = 1'b0; base_data = '0; offset = '0;
    store_data = '0; rd = '0; rn = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    test_reset();
    nreset = 1'b0;
    tick();
    test_reset();
    test_directed();
    test_cond_fail_and_busy_start();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the multi-cycle ARM core. Sits directly downstream of the execute stage and consumes its outputs: condition result, shifted offset, base/store data and the SDT control bits.
- Computes the effective address with pre/post indexing and up/down offset, then runs a req/ack transaction to data memory.
- Formats load data (byte lane extract or unaligned word rotate) and produces register-file write requests for Rd (load result) and Rn (base writeback).

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before the access is aborted with fault (legal 2..255)

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  reset; asynchronous, active-high despite name
start  in  1  one-cycle pulse from execute stage: operands valid
cond_pass  in  1  condition test result for this instruction
load_store  in  1  1=LDR, 0=STR
byte_or_word  in  1  1=byte, 0=word
pre_post  in  1  1=pre-index, 0=post-index
up_down  in  1  1=add offset, 0=subtract
write_back  in  1  W bit
base_data  in  32  Rn value
offset  in  32  offset from shifter (imm12 zero-extended or shifted Rm)
store_data  in  32  Rd value for STR
rd  in  4  Rd index
rn  in  4  Rn index
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write
mem_addr  out  32  word-aligned address
mem_wdata  out  32  write data
mem_be  out  4  byte enables, bit i = bits 8i+7:8i
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion
busy  out  1  high from cycle after start until done
done  out  1  one-cycle completion pulse
fault  out  1  with done: access timed out
rd_we  out  1  write Rd (with done)
rd_addr  out  4  Rd index
rd_data  out  32  load result
rn_we  out  1  write Rn (with done)
rn_addr  out  4  Rn index
rn_data  out  32  updated base

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (nreset).
- Reset: state IDLE, counter 0. All outputs 0, including mem_req, busy and done. Reset mid-transaction drops mem_req immediately; no done, no writes; a late mem_ack is ignored.
- All outputs are registered. All inputs are latched on start in IDLE. start while busy is ignored.
- Arithmetic: sum = up_down ? base+offset : base-offset, modulo 2^32. eff = pre_post ? sum : base_data.
- mem_addr = {eff[31:2],2'b00}. lane = eff[1:0].
- FSM: IDLE, ACCESS, WB.
  - IDLE + start + cond_pass=1 -> ACCESS; mem_req=1 next cycle.
  - IDLE + start + cond_pass=0 -> WB with no mem_req; done=1, rd_we=rn_we=fault=0.
  - ACCESS: mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ack is sampled high -> WB, with mem_req=0 in WB.
  - ACCESS timeout: counter increments each ACCESS cycle without ack. At TIMEOUT_CYCLES -> WB with fault=1, mem_req dropped, no writes.
  - mem_ack and timeout in the same cycle: ack wins.
  - WB: done=1 for exactly one cycle -> IDLE. busy=0 in IDLE.
- Latency: start at cycle 0 -> mem_req at 1. Ack sampled at cycle k -> done at k+1. Zero-wait ack at cycle 1 -> done at cycle 2.
- Store:
  - Word: mem_be=4'hF, mem_wdata=store_data; low address bits ignored.
  - Byte: mem_be=1<<lane, mem_wdata={4{store_data[7:0]}}.
- Load:
  - Byte: rd_data = zero-extended mem_rdata byte at lane (little-endian).
  - Word: rd_data = mem_rdata rotated right by 8*lane.
  - rd_data is captured on ack. rd_we=1 for loads only. mem_be=4'hF on all reads.
- Base writeback: rn_we = (write_back | ~pre_post) on a non-faulted, executed access; rn_data = sum.
  - Load with rd==rn and base writeback: load wins; rn_we=0, rd_we=1.
- rd_addr and rn_addr always reflect the latched indices. rd_we and rn_we are only ever high together with done.
- mem_ack outside ACCESS is ignored.

Test Plan:
- LDR word pre-index up: base=0x100, offset=0x8, mem_rdata=0xDEADBEEF, ack on 3rd req cycle -> mem_addr=0x108, done at cycle 4, rd_data=0xDEADBEEF, rd_we=1, rn_we=0.
- STRB post-index down with writeback: base=0x203, offset=4, store_data=0x12345678 -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0x78787878, mem_we=1, rn_we=1, rn_data=0x1FF.
- Unaligned LDR at eff=0x102, mem_rdata=0x11223344 -> rd_data=0x33441122. LDRB at lane 1 -> rd_data=0x00000033.
- cond_pass=0 -> no mem_req, done 1 cycle after start, rd_we=rn_we=0. Extra start pulses while busy -> single transaction.
- mem_ack never arrives (TIMEOUT_CYCLES=16) -> mem_req high exactly 16 cycles, then done=1, fault=1, no writes. Next start proceeds normally.
- nreset asserted mid-ACCESS -> mem_req=0 immediately, busy=0, no done. Address wrap: base=0xFFFFFFFC, offset=8, up -> mem_addr=0x4.
